force_release_arbiter: RTL

//  Shares a WIDTH-bit state register between N_REQ requesters that each want to

---
 rtl/force_release_arbiter_pkg.sv | 14 +
 rtl/force_release_arbiter_rr.sv | 32 +++
 rtl/force_release_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/force_release_arbiter_pkg.sv
// rtl/force_release_arbiter_pkg.sv - shared types and default sizes for the force/release arbiter
package force_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORCE   = 2'd1,
    RELEASE = 2'd2
  } farb_state_t;

endpackage

// File: rtl/force_release_arbiter_rr.sv
// rtl/force_release_arbiter_rr.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] win_o,
  output logic             any_o
);

  int idx;

  // Scan from the farthest slot back to ptr_i so the closest requester wins last.
  always_comb begin
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) begin
        win_o = IDX_W'(idx);
        any_o = 1'b1;
      end
    end
    if (any_o) gnt_o[win_o] = 1'b1;
  end

endmodule

// File: rtl/force_release_arbiter.sv
// rtl/force_release_arbiter.sv - time-limited force of a shared register with round-robin arbitration
module force_release_arbiter
  import force_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    req_val,
  input  logic [N_REQ*HOLD_W-1:0]   req_hold,
  input  logic                      abort,
  input  logic                      func_en,
  input  logic [WIDTH-1:0]          func_d,
  output logic [N_REQ-1:0]          gnt,
  output logic [WIDTH-1:0]          q,
  output logic                      forced,
  output logic                      done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  farb_state_t       state_q;
  logic [WIDTH-1:0]  q_reg_q;
  logic [WIDTH-1:0]  fval_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [IDX_W-1:0]  rr_ptr_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_win;
  logic              pick_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .win_o (pick_win),
    .any_o (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_reg_q  <= '0;
      fval_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (func_en) q_reg_q <= func_d;
          if (pick_any) begin
            fval_q   <= req_val[int'(pick_win)*WIDTH +: WIDTH];
            cnt_q    <= req_hold[int'(pick_win)*HOLD_W +: HOLD_W];
            rr_ptr_q <= (pick_win == IDX_W'(N_REQ - 1)) ? '0 : pick_win + IDX_W'(1);
            state_q  <= FORCE;
          end
        end
        FORCE: begin
          // Zero test comes first so the count can never wrap.
          if (cnt_q == '0 || abort) state_q <= RELEASE;
          else cnt_q <= cnt_q - HOLD_W'(1);
        end
        RELEASE: begin
          q_reg_q <= fval_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt    = (state_q == IDLE && rst_n) ? pick_gnt : '0;
  assign forced = (state_q == FORCE);
  assign done   = (state_q == RELEASE);
  assign q      = (state_q == IDLE) ? q_reg_q : fval_q;

endmodule
